// File: rtl/ray_column_sequencer.sv
// Per-frame ray sweep: launches both wall finders for each screen column, picks the nearer
// hit by squared distance and hands one record per column to the renderer.
module ray_column_sequencer #(
    parameter int unsigned NUM_COLS = 160,
    parameter int unsigned FOV      = 60,
    parameter int unsigned ANG_STEP = 96,
    parameter int unsigned TIMEOUT  = 1023
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic signed [11:0] playerX,
    input  logic signed [11:0] playerY,
    input  logic signed [11:0] player_angle,
    output logic signed [11:0] alpha,
    output logic               begin_calc,
    input  logic signed [11:0] h_wallX,
    input  logic signed [11:0] h_wallY,
    input  logic signed [11:0] v_wallX,
    input  logic signed [11:0] v_wallY,
    input  logic               h_wall_found,
    input  logic               v_wall_found,
    input  logic               h_end_calc,
    input  logic               v_end_calc,
    output logic [7:0]         col_index,
    output logic signed [11:0] col_wallX,
    output logic signed [11:0] col_wallY,
    output logic [24:0]        col_dist_sq,
    output logic               col_hit,
    output logic               col_is_vert,
    output logic               col_valid,
    input  logic               col_ready,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned ACC_W  = 17;
    localparam int unsigned DIST_W = 25;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [19:0] TURN_20 = 20'(360 * 256);
    localparam logic [17:0] TURN_18 = 18'(360 * 256);
    localparam logic [17:0] STEP_18 = 18'(ANG_STEP);
    localparam logic [19:0] HALF_FOV_20 = 20'(FOV / 2);
    localparam logic [7:0]  LAST_COL = 8'(NUM_COLS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DIST_W-1:0] NO_HIT_DIST = {DIST_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_DIFF, S_SQUARE, S_SELECT, S_EMIT, S_ADVANCE
    } state_t;

    state_t state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic signed [11:0] px_q, px_d, py_q, py_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               h_done_q, h_done_d, v_done_q, v_done_d;
    logic               h_found_q, h_found_d, v_found_q, v_found_d;
    logic signed [11:0] hx_q, hx_d, hy_q, hy_d, vx_q, vx_d, vy_q, vy_d;
    logic signed [12:0] dxh_q, dxh_d, dyh_q, dyh_d, dxv_q, dxv_d, dyv_q, dyv_d;
    logic [DIST_W-1:0]  dh_q, dh_d, dv_q, dv_d;

    logic signed [11:0] alpha_q, alpha_d;
    logic               begin_calc_q, begin_calc_d;
    logic [7:0]         col_index_q, col_index_d;
    logic signed [11:0] col_wall_x_q, col_wall_x_d, col_wall_y_q, col_wall_y_d;
    logic [DIST_W-1:0]  col_dist_q, col_dist_d;
    logic               col_hit_q, col_hit_d, col_is_vert_q, col_is_vert_d;
    logic               col_valid_q, col_valid_d;
    logic               busy_q, busy_d, frame_done_q, frame_done_d;

    logic [19:0]      start_raw, start_mod;
    logic [17:0]      step_raw, step_mod;
    logic             use_h, use_v, pick_v;

    function automatic logic [DIST_W-1:0] sq(input logic signed [12:0] a);
        logic signed [25:0] w;
        w = 26'(a);
        return DIST_W'(w * w);
    endfunction

    // Angle accumulator seed and per-column step, both kept in [0, 360*256)
    always_comb begin
        start_raw = ({8'd0, player_angle} + HALF_FOV_20) << 8;
        start_mod = (start_raw >= TURN_20) ? (start_raw - TURN_20) : start_raw;
        step_raw  = {1'b0, acc_q} - STEP_18;
        step_mod  = step_raw[17] ? (step_raw + TURN_18) : step_raw;
    end

    // A finder that never reported is treated as a miss regardless of its found input
    always_comb begin
        use_h  = h_done_q & h_found_q;
        use_v  = v_done_q & v_found_q;
        pick_v = use_v & (~use_h | (dv_q < dh_q));
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        px_d         = px_q;
        py_d         = py_q;
        cnt_d        = cnt_q;
        h_done_d     = h_done_q;
        v_done_d     = v_done_q;
        h_found_d    = h_found_q;
        v_found_d    = v_found_q;
        hx_d         = hx_q;
        hy_d         = hy_q;
        vx_d         = vx_q;
        vy_d         = vy_q;
        dxh_d        = dxh_q;
        dyh_d        = dyh_q;
        dxv_d        = dxv_q;
        dyv_d        = dyv_q;
        dh_d         = dh_q;
        dv_d         = dv_q;
        col_index_d  = col_index_q;
        col_wall_x_d = col_wall_x_q;
        col_wall_y_d = col_wall_y_q;
        col_dist_d   = col_dist_q;
        col_hit_d    = col_hit_q;
        col_is_vert_d = col_is_vert_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    px_d        = playerX;
                    py_d        = playerY;
                    col_index_d = 8'd0;
                    acc_d       = ACC_W'(start_mod);
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                h_done_d = 1'b0;
                v_done_d = 1'b0;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (h_end_calc) begin
                    h_done_d  = 1'b1;
                    hx_d      = h_wallX;
                    hy_d      = h_wallY;
                    h_found_d = h_wall_found;
                end
                if (v_end_calc) begin
                    v_done_d  = 1'b1;
                    vx_d      = v_wallX;
                    vy_d      = v_wallY;
                    v_found_d = v_wall_found;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if ((h_done_d && v_done_d) || (cnt_q == CNT_LAST)) begin
                    state_d = S_DIFF;
                end
            end
            S_DIFF: begin
                dxh_d   = {hx_q[11], hx_q} - {px_q[11], px_q};
                dyh_d   = {hy_q[11], hy_q} - {py_q[11], py_q};
                dxv_d   = {vx_q[11], vx_q} - {px_q[11], px_q};
                dyv_d   = {vy_q[11], vy_q} - {py_q[11], py_q};
                state_d = S_SQUARE;
            end
            S_SQUARE: begin
                dh_d    = sq(dxh_q) + sq(dyh_q);
                dv_d    = sq(dxv_q) + sq(dyv_q);
                state_d = S_SELECT;
            end
            S_SELECT: begin
                col_hit_d     = use_h | use_v;
                col_is_vert_d = pick_v;
                if (pick_v) begin
                    col_wall_x_d = vx_q;
                    col_wall_y_d = vy_q;
                    col_dist_d   = dv_q;
                end else if (use_h) begin
                    col_wall_x_d = hx_q;
                    col_wall_y_d = hy_q;
                    col_dist_d   = dh_q;
                end else begin
                    col_wall_x_d = 12'sd0;
                    col_wall_y_d = 12'sd0;
                    col_dist_d   = NO_HIT_DIST;
                end
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (col_ready) begin
                    frame_done_d = (col_index_q == LAST_COL);
                    state_d      = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (col_index_q == LAST_COL) begin
                    state_d = S_IDLE;
                end else begin
                    col_index_d = col_index_q + 8'd1;
                    acc_d       = ACC_W'(step_mod);
                    state_d     = S_LAUNCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs registered against the state being entered
        begin_calc_d = (state_d == S_LAUNCH);
        col_valid_d  = (state_d == S_EMIT);
        busy_d       = (state_d != S_IDLE);
        alpha_d      = {3'b000, acc_d[16:8]};
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            acc_q         <= '0;
            px_q          <= '0;
            py_q          <= '0;
            cnt_q         <= '0;
            h_done_q      <= 1'b0;
            v_done_q      <= 1'b0;
            h_found_q     <= 1'b0;
            v_found_q     <= 1'b0;
            hx_q          <= '0;
            hy_q          <= '0;
            vx_q          <= '0;
            vy_q          <= '0;
            dxh_q         <= '0;
            dyh_q         <= '0;
            dxv_q         <= '0;
            dyv_q         <= '0;
            dh_q          <= '0;
            dv_q          <= '0;
            alpha_q       <= '0;
            begin_calc_q  <= 1'b0;
            col_index_q   <= '0;
            col_wall_x_q  <= '0;
            col_wall_y_q  <= '0;
            col_dist_q    <= '0;
            col_hit_q     <= 1'b0;
            col_is_vert_q <= 1'b0;
            col_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            px_q          <= px_d;
            py_q          <= py_d;
            cnt_q         <= cnt_d;
            h_done_q      <= h_done_d;
            v_done_q      <= v_done_d;
            h_found_q     <= h_found_d;
            v_found_q     <= v_found_d;
            hx_q          <= hx_d;
            hy_q          <= hy_d;
            vx_q          <= vx_d;
            vy_q          <= vy_d;
            dxh_q         <= dxh_d;
            dyh_q         <= dyh_d;
            dxv_q         <= dxv_d;
            dyv_q         <= dyv_d;
            dh_q          <= dh_d;
            dv_q          <= dv_d;
            alpha_q       <= alpha_d;
            begin_calc_q  <= begin_calc_d;
            col_index_q   <= col_index_d;
            col_wall_x_q  <= col_wall_x_d;
            col_wall_y_q  <= col_wall_y_d;
            col_dist_q    <= col_dist_d;
            col_hit_q     <= col_hit_d;
            col_is_vert_q <= col_is_vert_d;
            col_valid_q   <= col_valid_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign alpha       = alpha_q;
    assign begin_calc  = begin_calc_q;
    assign col_index   = col_index_q;
    assign col_wallX   = col_wall_x_q;
    assign col_wallY   = col_wall_y_q;
    assign col_dist_sq = col_dist_q;
    assign col_hit     = col_hit_q;
    assign col_is_vert = col_is_vert_q;
    assign col_valid   = col_valid_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ray_column_sequencer.sv
// Directed bench for ray_column_sequencer: angle sweeps, nearest-hit selection table,
// strobe ordering, timeout, backpressure and mid-frame reset.
module tb_ray_column_sequencer;

    localparam int NUM_COLS = 160;
    localparam int TURN     = 92160;
    localparam int STEP     = 96;
    localparam int NV       = 8;

    logic               clock;
    logic               resetn;
    logic               start;
    logic signed [11:0] playerX, playerY, player_angle;
    logic signed [11:0] alpha;
    logic               begin_calc;
    logic signed [11:0] h_wallX, h_wallY, v_wallX, v_wallY;
    logic               h_wall_found, v_wall_found, h_end_calc, v_end_calc;
    logic [7:0]         col_index;
    logic signed [11:0] col_wallX, col_wallY;
    logic [24:0]        col_dist_sq;
    logic               col_hit, col_is_vert, col_valid, col_ready, busy, frame_done;

    ray_column_sequencer dut (
        .clock(clock), .resetn(resetn), .start(start),
        .playerX(playerX), .playerY(playerY), .player_angle(player_angle),
        .alpha(alpha), .begin_calc(begin_calc),
        .h_wallX(h_wallX), .h_wallY(h_wallY), .v_wallX(v_wallX), .v_wallY(v_wallY),
        .h_wall_found(h_wall_found), .v_wall_found(v_wall_found),
        .h_end_calc(h_end_calc), .v_end_calc(v_end_calc),
        .col_index(col_index), .col_wallX(col_wallX), .col_wallY(col_wallY),
        .col_dist_sq(col_dist_sq), .col_hit(col_hit), .col_is_vert(col_is_vert),
        .col_valid(col_valid), .col_ready(col_ready), .busy(busy), .frame_done(frame_done)
    );

    typedef struct {
        int     hx, hy;
        bit     hf;
        int     vx, vy;
        bit     vf;
        int     h_lat, v_lat, hold;
        bit     e_hit, e_vert;
        int     e_x, e_y;
        longint e_dist;
        int     e_lat;
    } vec_t;

    vec_t tbl[NV];
    int   total = 0;
    int   bad = 0;
    int   h_lat_cfg = -1;
    int   v_lat_cfg = -1;
    int   since;
    int   fd_count = 0;
    int   exp_fd = 0;

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Finder stand-in: strobes a fixed number of cycles after each launch pulse
    initial begin
        h_end_calc = 1'b0;
        v_end_calc = 1'b0;
        since = 1000000;
        forever begin
            @(negedge clock);
            if (begin_calc) since = 0;
            else if (since < 1000000) since++;
            h_end_calc = (h_lat_cfg > 0) && (since == h_lat_cfg);
            v_end_calc = (v_lat_cfg > 0) && (since == v_lat_cfg);
        end
    end

    always @(negedge clock) if (frame_done) fd_count++;

    function automatic vec_t mk(int hx, int hy, bit hf, int vx, int vy, bit vf,
                                int hl, int vl, int hold, bit eh, bit ev,
                                int ex, int ey, longint ed, int el);
        vec_t v;
        v.hx = hx; v.hy = hy; v.hf = hf; v.vx = vx; v.vy = vy; v.vf = vf;
        v.h_lat = hl; v.v_lat = vl; v.hold = hold;
        v.e_hit = eh; v.e_vert = ev; v.e_x = ex; v.e_y = ey; v.e_dist = ed; v.e_lat = el;
        return v;
    endfunction

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_alpha"}, longint'(alpha), 0);
        chk({tag, "_begin_calc"}, longint'(begin_calc), 0);
        chk({tag, "_col_index"}, longint'(col_index), 0);
        chk({tag, "_col_wallX"}, longint'(col_wallX), 0);
        chk({tag, "_col_wallY"}, longint'(col_wallY), 0);
        chk({tag, "_col_dist_sq"}, longint'(col_dist_sq), 0);
        chk({tag, "_col_hit"}, longint'(col_hit), 0);
        chk({tag, "_col_is_vert"}, longint'(col_is_vert), 0);
        chk({tag, "_col_valid"}, longint'(col_valid), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_frame_done"}, longint'(frame_done), 0);
    endtask

    task automatic chk_record(input string tag, input vec_t v);
        chk({tag, "_hit"}, longint'(col_hit), longint'(v.e_hit));
        chk({tag, "_vert"}, longint'(col_is_vert), longint'(v.e_vert));
        chk({tag, "_x"}, longint'($signed(col_wallX)), longint'(v.e_x));
        chk({tag, "_y"}, longint'($signed(col_wallY)), longint'(v.e_y));
        chk({tag, "_dist"}, longint'(col_dist_sq), v.e_dist);
    endtask

    // One column: launch, wait for the record, hold it under backpressure, accept it
    task automatic do_column(input int c, input vec_t v, input int exp_alpha, input bit last);
        int  n, iter, launch_iter;
        bit  got;
        string tag;
        tag = $sformatf("c%0d", c);
        h_wallX = 12'(v.hx); h_wallY = 12'(v.hy); h_wall_found = v.hf;
        v_wallX = 12'(v.vx); v_wallY = 12'(v.vy); v_wall_found = v.vf;
        h_lat_cfg = v.h_lat; v_lat_cfg = v.v_lat;
        col_ready = 1'b0;
        n = -1; iter = 0; launch_iter = -1; got = 1'b0;
        while (!got && iter < 2000) begin
            @(negedge clock);
            iter++;
            if (begin_calc) begin
                n = 0;
                if (launch_iter < 0) launch_iter = iter;
                chk({tag, "_launch_alpha"}, longint'(alpha), longint'(exp_alpha));
            end else if (n >= 0) begin
                n++;
            end
            if (col_valid) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_valid_wait: got no col_valid, expected one within 2000 cycles", tag);
            finish_up();
        end
        chk({tag, "_launch_delay"}, longint'(launch_iter), 1);
        chk({tag, "_latency"}, longint'(n), longint'(v.e_lat));
        chk({tag, "_index"}, longint'(col_index), longint'(c));
        chk({tag, "_alpha"}, longint'(alpha), longint'(exp_alpha));
        chk({tag, "_busy"}, longint'(busy), 1);
        chk_record(tag, v);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clock);
            chk($sformatf("%s_hold%0d_valid", tag, h), longint'(col_valid), 1);
            chk_record($sformatf("%s_hold%0d", tag, h), v);
        end
        col_ready = 1'b1;
        @(negedge clock);
        col_ready = 1'b0;
        chk({tag, "_valid_drop"}, longint'(col_valid), 0);
        chk({tag, "_frame_done"}, longint'(frame_done), longint'(last));
    endtask

    task automatic run_frame(input int ang, input bit use_tbl);
        int   acc, a_now, prev, maxa;
        bit   crossed;
        vec_t v;
        string tag;
        tag = $sformatf("ang%0d", ang);
        acc = ((ang + 30) * 256) % TURN;
        prev = -1; maxa = 0; crossed = 1'b0;
        playerX = 12'sd100; playerY = 12'sd100; player_angle = 12'(ang);
        start = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (c == NUM_COLS - 1) start = 1'b0;
            if (use_tbl && c < NV) v = tbl[c];
            else v = tbl[0];
            do_column(c, v, acc / 256, c == NUM_COLS - 1);
            a_now = int'(alpha);
            if (prev == 0 && a_now == 359) crossed = 1'b1;
            if (a_now > maxa) maxa = a_now;
            if (ang == 90 && c == 0) chk("sweep_c0_alpha", longint'(a_now), 120);
            if (ang == 90 && c == 1) chk("sweep_c1_alpha", longint'(a_now), 119);
            if (ang == 90 && c == 159) chk("sweep_c159_alpha", longint'(a_now), 60);
            if (ang == 350 && c == 0) chk("wrap_c0_alpha", longint'(a_now), 20);
            if (ang == 350 && c == 159) chk("wrap_c159_alpha", longint'(a_now), 320);
            if (ang == 0 && c == 0) chk("restart_c0_alpha", longint'(a_now), 30);
            prev = a_now;
            acc -= STEP;
            if (acc < 0) acc += TURN;
        end
        exp_fd++;
        @(negedge clock);
        chk({tag, "_end_busy"}, longint'(busy), 0);
        chk({tag, "_end_frame_done"}, longint'(frame_done), 0);
        chk({tag, "_frame_done_count"}, longint'(fd_count), longint'(exp_fd));
        chk({tag, "_alpha_below_360"}, longint'(maxa <= 359), 1);
        if (ang == 350) chk("wrap_crossed_0_to_359", longint'(crossed), 1);
    endtask

    initial begin
        //            hx   hy  hf   vx   vy  vf  hl  vl hold hit vert  ex   ey  dist       lat
        tbl[0] = mk(150, 100, 1, 100, 130, 1,  1,  1, 0,   1, 1,  100, 130, 900,       5);
        tbl[1] = mk(150, 100, 1, 100, 150, 1,  1,  1, 0,   1, 0,  150, 100, 2500,      5);
        tbl[2] = mk(150, 100, 1, 100, 130, 1,  7,  2, 0,   1, 1,  100, 130, 900,       11);
        tbl[3] = mk( 90, 100, 1, 100, 120, 1,  3,  3, 0,   1, 0,   90, 100, 100,       7);
        tbl[4] = mk(100,  70, 1,  95, 100, 1,  3,  3, 0,   1, 1,   95, 100, 25,        7);
        tbl[5] = mk(300, 300, 1, 100, 101, 0, -1,  2, 0,   0, 0,    0,   0, 33554431,  1027);
        tbl[6] = mk( 40, 180, 1, 100, 101, 0,  1,  4, 3,   1, 0,   40, 180, 10000,     8);
        tbl[7] = mk(100, 100, 0, -20, 100, 1,  2,  2, 7,   1, 1,  -20, 100, 14400,     6);

        resetn = 1'b0; start = 1'b0; col_ready = 1'b0;
        playerX = '0; playerY = '0; player_angle = '0;
        h_wallX = '0; h_wallY = '0; v_wallX = '0; v_wallY = '0;
        h_wall_found = 1'b0; v_wall_found = 1'b0;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        resetn = 1'b1;
        @(negedge clock);
        chk("idle_busy", longint'(busy), 0);

        run_frame(90, 1'b0);
        run_frame(350, 1'b1);

        // Abort a frame while a record is pending, then start over
        playerX = 12'sd100; playerY = 12'sd100; player_angle = 12'sd200;
        start = 1'b1;
        do_column(0, tbl[0], 230, 1'b0);
        start = 1'b0;
        do_column(1, tbl[0], 229, 1'b0);
        begin
            int k;
            k = 0;
            while (!col_valid && k < 100) begin
                @(negedge clock);
                k++;
            end
            chk("abort_pending_valid", longint'(col_valid), 1);
        end
        resetn = 1'b0;
        @(negedge clock);
        chk_zero("midframe_reset");
        resetn = 1'b1;
        @(negedge clock);
        chk("post_reset_busy", longint'(busy), 0);
        chk("post_reset_valid", longint'(col_valid), 0);

        run_frame(0, 1'b0);
        finish_up();
    end

endmodule

// File: doc/ray_column_sequencer.md
# ray_column_sequencer

Frame-level sequencer that sits directly upstream of the horizontal and vertical wall-intersection finders. On `start` it sweeps the field of view one screen column at a time: it drives a stable ray angle and a `begin_calc` pulse to both finders, collects their `end_calc` results, and picks the nearer hit by squared Euclidean distance. It then emits one column record per ray to the wall-slice renderer with a valid/ready handshake.

## Interface
Parameters:
- `NUM_COLS`, 160: columns per frame (≤256).
- `FOV`, 60: field of view in whole degrees.
- `ANG_STEP`, 96: per-column angle step in 1/256-degree units; must equal FOV·256/NUM_COLS.
- `TIMEOUT`, 1023: max cycles spent waiting for the finders per column.

Ports:
- `clock` in 1: system clock, 50 MHz.
- `resetn` in 1: reset, synchronous, active-low.
- `start` in 1: begin a frame; sampled only in IDLE.
- `playerX`, `playerY` in 12 signed: player position; latched on accepted `start`.
- `player_angle` in 12 signed: heading in degrees, 0..359; latched on accepted `start`.
- `alpha` out 12 signed: current ray angle, 0..359; held stable from LAUNCH to the end of WAIT.
- `begin_calc` out 1: one-cycle launch pulse to both finders.
- `h_wallX`, `h_wallY`, `v_wallX`, `v_wallY` in 12 signed: finder results.
- `h_wall_found`, `v_wall_found` in 1: finder hit flags.
- `h_end_calc`, `v_end_calc` in 1: finder completion strobes.
- `col_index` out 8: column number, 0..NUM_COLS-1.
- `col_wallX`, `col_wallY` out 12 signed: chosen hit point.
- `col_dist_sq` out 25 unsigned: dx²+dy² of the chosen hit.
- `col_hit` out 1: at least one finder found a wall.
- `col_is_vert` out 1: the chosen hit came from the vertical finder.
- `col_valid` out 1: column record valid.
- `col_ready` in 1: downstream accepts the record.
- `busy` out 1: high in any state except IDLE.
- `frame_done` out 1: one-cycle pulse after the last column is accepted.

## Operation
- States: IDLE, LAUNCH, WAIT, DIFF, SQUARE, SELECT, EMIT, ADVANCE.
- IDLE → LAUNCH on `start`:
  - latch player inputs;
  - set `col_index`=0;
  - set the 17-bit angle accumulator `acc` = (player_angle + FOV/2)·256, reduced mod 92160 (360·256).
- `alpha` = `acc[16:8]`, zero-extended to 12 bits.
- LAUNCH:
  - `begin_calc`=1 for exactly one cycle;
  - clear the sticky flags h_done and v_done;
  - clear the timeout counter.
  - → WAIT.
- WAIT:
  - On any cycle `h_end_calc`=1: set h_done and capture `h_wallX/Y` and `h_wall_found`. Same rule for the v inputs.
  - Simultaneous h and v strobes are both captured.
  - Strobes seen outside WAIT are ignored.
  - → DIFF when h_done && v_done.
  - Also → DIFF when the counter reaches TIMEOUT; any finder without done is treated as found=0.
- DIFF: register dxh, dyh, dxv, dyv = wall − player, 13-bit signed.
- SQUARE: register dh = dxh²+dyh² and dv = dxv²+dyv², 25-bit unsigned.
- SELECT:
  - Both found: choose the smaller distance; a tie chooses horizontal.
  - Only one found: choose that one.
  - Neither found: `col_hit`=0, wall coordinates=0, `col_dist_sq`=25'h1FFFFFF.
  - → EMIT.
- EMIT: `col_valid`=1 with all `col_*` outputs stable; stay until `col_ready`=1.
- ADVANCE:
  - If `col_index`==NUM_COLS-1: pulse `frame_done` → IDLE.
  - Else: `col_index`+1; `acc` = `acc` − ANG_STEP, adding 92160 if the result is negative → LAUNCH.
- `start` is ignored while `busy`.

## Timing
- Reset values:
  - all outputs 0, except `col_dist_sq`=0;
  - state IDLE, `acc`=0.
- Reset mid-frame aborts immediately and drops any pending record; the next `start` begins a fresh frame at column 0.
- `start` → `begin_calc`: 1 cycle (IDLE, then LAUNCH).
- Last `end_calc` → `col_valid`: 4 cycles (WAIT exit, DIFF, SQUARE, SELECT).
- `col_valid`&&`col_ready` → next `begin_calc`: 2 cycles (ADVANCE, LAUNCH).
- `frame_done` asserts in the ADVANCE cycle; `busy` drops the following cycle.
- `alpha` changes only in ADVANCE and on `start` acceptance.

## Test plan
- **Angle sweep:** `player_angle`=90, NUM_COLS=160, finders ending immediately.
  - Required: col0 `alpha`=120, col1 119, col159 60;
  - 160 records, then one `frame_done`.
- **Wrap:** `player_angle`=350.
  - Required: col0 `alpha`=20;
  - the sweep crosses 0 → 359 with no value ≥360;
  - col159 `alpha`=320.
- **Nearest select:** player (100,100), h hit (150,100), v hit (100,130), both found.
  - Required: `col_is_vert`=1, `col_wallX`=100, `col_wallY`=130, `col_dist_sq`=900.
  - Repeat with v hit (100,150): tie at 2500, so `col_is_vert`=0.
- **Ordering and simultaneity:**
  - v strobe 5 cycles before h strobe: record appears 4 cycles after the h strobe.
  - Both strobes in the same cycle: both results captured.
- **Timeout / no hit:** h never strobes; v strobes with found=0.
  - Required: record after TIMEOUT cycles with `col_hit`=0 and `col_dist_sq`=0x1FFFFFF.
- **Backpressure and reset:**
  - `col_ready` low for 7 cycles: record held stable with `col_valid`=1 throughout.
  - `resetn` low mid-frame: all outputs 0; a new `start` restarts at `col_index`=0.
